keypad_auth: RTL and testbench

KEYPAD_AUTH -- requirements
Module: keypad_auth

---
 rtl/keypad_auth.sv | 241 ++++++++++++++++++++++++
 tb/tb_keypad_auth.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_auth.sv
// keypad_auth -- keypad login controller with a programmable credential table.
//
// A login is: star, USER_DIGITS BCD username digits, PASS_DIGITS BCD password
// digits. The entry is checked for one cycle. A registered login_ok or
// login_fail pulse follows. A passing login opens a session that stays open
// until hash (log out) or star (start a new login).
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active low
//   key_valid    in   one-cycle key strobe
//   key          in   0-9 digit, 10 star, 11 hash, 12-15 ignored
//   prog_we      in   credential write strobe
//   prog_user    in   user index to program (out-of-range ignored)
//   prog_pass    in   new BCD password, most significant digit first
//   logged_in    out  session open
//   cur_user     out  logged-in user index, 0 when no session
//   login_ok     out  one-cycle pulse, login accepted
//   login_fail   out  one-cycle pulse, login rejected
//   timeout      out  one-cycle pulse, entry abandoned by idling
//   locked       out  per-user lockout flags
//   entry_active out  a login is being typed or checked
module keypad_auth #(
  parameter  int USER_DIGITS = 3,
  parameter  int PASS_DIGITS = 4,
  parameter  int NUM_USERS   = 8,
  parameter  int MAX_FAILS   = 3,
  parameter  int TIMEOUT     = 64,
  localparam int UW          = $clog2(NUM_USERS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [3:0]               key,
  input  logic                     prog_we,
  input  logic [UW-1:0]            prog_user,
  input  logic [4*PASS_DIGITS-1:0] prog_pass,
  output logic                     logged_in,
  output logic [UW-1:0]            cur_user,
  output logic                     login_ok,
  output logic                     login_fail,
  output logic                     timeout,
  output logic [NUM_USERS-1:0]     locked,
  output logic                     entry_active
);

  localparam int UDW = 4*USER_DIGITS;
  localparam int PDW = 4*PASS_DIGITS;

  typedef enum logic [2:0] {S_IDLE, S_USER, S_PASS, S_CHECK, S_SESSION} state_t;

  // BCD image of a user index, used as that user's password after reset.
  function automatic logic [PDW-1:0] to_bcd(input int value);
    logic [PDW-1:0] bcd;
    int             v;
    bcd = '0;
    v   = value;
    for (int d = 0; d < PASS_DIGITS; d++) begin
      bcd[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return bcd;
  endfunction

  state_t         r_state, w_state_next;
  logic [UDW-1:0] r_user, w_user_next;
  logic [PDW-1:0] r_pass, w_pass_next;
  logic [7:0]     r_dcnt, w_dcnt_next;
  logic [15:0]    r_idle, w_idle_next;
  logic           r_logged_in, w_logged_in_next;
  logic [UW-1:0]  r_cur_user, w_cur_user_next;
  logic           r_ok, w_ok_next;
  logic           r_fail, w_fail_next;
  logic           r_timeout, w_timeout_next;

  // The credential table has per-entry reset values, so it lives in flops.
  logic [PDW-1:0]       r_table [NUM_USERS];
  logic [3:0]           r_fails [NUM_USERS];
  logic [NUM_USERS-1:0] r_locked;

  logic        w_digit, w_star, w_hash;
  logic [31:0] w_user_val;
  logic        w_in_range, w_match, w_fail_inc, w_pass_clear;
  logic [UW-1:0] w_uidx;

  assign w_digit = key_valid && (key <= 4'd9);
  assign w_star  = key_valid && (key == 4'd10);
  assign w_hash  = key_valid && (key == 4'd11);

  // Decimal value of the typed username; only in-range values index the table.
  always_comb begin
    w_user_val = '0;
    for (int d = USER_DIGITS-1; d >= 0; d--)
      w_user_val = w_user_val * 32'd10 + 32'(r_user[4*d +: 4]);
  end

  assign w_in_range   = (w_user_val < 32'(NUM_USERS));
  assign w_uidx       = w_user_val[UW-1:0];
  assign w_match      = w_in_range && !r_locked[w_uidx] && (r_table[w_uidx] == r_pass);
  assign w_fail_inc   = (r_state == S_CHECK) && !w_match && w_in_range;
  assign w_pass_clear = (r_state == S_CHECK) && w_match;

  always_comb begin
    w_state_next     = r_state;
    w_user_next      = r_user;
    w_pass_next      = r_pass;
    w_dcnt_next      = r_dcnt;
    w_idle_next      = r_idle;
    w_logged_in_next = r_logged_in;
    w_cur_user_next  = r_cur_user;
    w_ok_next        = 1'b0;
    w_fail_next      = 1'b0;
    w_timeout_next   = 1'b0;
    // Star restarts entry from every state except CHECK, closing any session.
    if (w_star && (r_state != S_CHECK)) begin
      w_state_next     = S_USER;
      w_user_next      = '0;
      w_pass_next      = '0;
      w_dcnt_next      = '0;
      w_idle_next      = '0;
      w_logged_in_next = 1'b0;
      w_cur_user_next  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
        end
        S_SESSION: begin
          if (w_hash) begin
            w_state_next     = S_IDLE;
            w_logged_in_next = 1'b0;
            w_cur_user_next  = '0;
          end
        end
        S_USER, S_PASS: begin
          if (w_hash) begin
            w_state_next = S_IDLE;
          end else if (w_digit) begin
            w_idle_next = '0;
            w_dcnt_next = r_dcnt + 8'd1;
            if (r_state == S_USER) begin
              w_user_next = (r_user << 4) | UDW'(key);
              if (r_dcnt == 8'(USER_DIGITS-1)) begin
                w_state_next = S_PASS;
                w_dcnt_next  = '0;
              end
            end else begin
              w_pass_next = (r_pass << 4) | PDW'(key);
              if (r_dcnt == 8'(PASS_DIGITS-1)) begin
                w_state_next = S_CHECK;
                w_dcnt_next  = '0;
              end
            end
          end else if (key_valid) begin
            // Ignored codes still count as activity.
            w_idle_next = '0;
          end else if (r_idle == 16'(TIMEOUT-1)) begin
            w_state_next   = S_IDLE;
            w_timeout_next = 1'b1;
          end else begin
            w_idle_next = r_idle + 16'd1;
          end
        end
        S_CHECK: begin
          if (w_match) begin
            w_state_next     = S_SESSION;
            w_logged_in_next = 1'b1;
            w_cur_user_next  = w_uidx;
            w_ok_next        = 1'b1;
          end else begin
            w_state_next = S_IDLE;
            w_fail_next  = 1'b1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_user      <= '0;
      r_pass      <= '0;
      r_dcnt      <= '0;
      r_idle      <= '0;
      r_logged_in <= 1'b0;
      r_cur_user  <= '0;
      r_ok        <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_user      <= w_user_next;
      r_pass      <= w_pass_next;
      r_dcnt      <= w_dcnt_next;
      r_idle      <= w_idle_next;
      r_logged_in <= w_logged_in_next;
      r_cur_user  <= w_cur_user_next;
      r_ok        <= w_ok_next;
      r_fail      <= w_fail_next;
      r_timeout   <= w_timeout_next;
    end
  end

  // Programming wins over a same-cycle failed check. The check itself
  // already read the old password this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_USERS; i++) begin
        r_table[i] <= to_bcd(i);
        r_fails[i] <= '0;
      end
      r_locked <= '0;
    end else begin
      for (int i = 0; i < NUM_USERS; i++) begin
        if (prog_we && (prog_user == UW'(i))) begin
          r_table[i]  <= prog_pass;
          r_fails[i]  <= '0;
          r_locked[i] <= 1'b0;
        end else if (w_fail_inc && (w_uidx == UW'(i))) begin
          if (r_fails[i] != 4'(MAX_FAILS)) begin
            r_fails[i] <= r_fails[i] + 4'd1;
            if (r_fails[i] == 4'(MAX_FAILS-1))
              r_locked[i] <= 1'b1;
          end
        end else if (w_pass_clear && (w_uidx == UW'(i))) begin
          r_fails[i] <= '0;
        end
      end
    end
  end

  assign logged_in    = r_logged_in;
  assign cur_user     = r_cur_user;
  assign login_ok     = r_ok;
  assign login_fail   = r_fail;
  assign timeout      = r_timeout;
  assign locked       = r_locked;
  assign entry_active = (r_state == S_USER) || (r_state == S_PASS) || (r_state == S_CHECK);

endmodule

// File: tb/tb_keypad_auth.sv
// tb_keypad_auth -- self-checking bench for keypad_auth (default parameters).
// Three parts. A table of hand-derived per-cycle vectors. Directed multi-cycle
// sequences. Random traffic checked against a digit-queue reference model.
module tb_keypad_auth;
  localparam int UD = 3, PD = 4, NU = 8, MF = 3, TO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key = 4'd0;
  logic        prog_we = 1'b0;
  logic [2:0]  prog_user = 3'd0;
  logic [15:0] prog_pass = 16'h0;
  logic        logged_in, login_ok, login_fail, timeout, entry_active;
  logic [2:0]  cur_user;
  logic [7:0]  locked;

  keypad_auth #(.USER_DIGITS(UD), .PASS_DIGITS(PD), .NUM_USERS(NU),
                .MAX_FAILS(MF), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key(key),
    .prog_we(prog_we), .prog_user(prog_user), .prog_pass(prog_pass),
    .logged_in(logged_in), .cur_user(cur_user), .login_ok(login_ok),
    .login_fail(login_fail), .timeout(timeout), .locked(locked),
    .entry_active(entry_active));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // {ok, fail, timeout, logged_in, cur_user[2:0], entry_active, locked[7:0]}
  function automatic logic [15:0] pk(input bit ok, input bit fl, input bit to, input bit li,
                                     input int cu, input bit ea, input logic [7:0] lk);
    return {ok, fl, to, li, 3'(cu), ea, lk};
  endfunction

  function automatic logic [15:0] outs();
    return {login_ok, login_fail, timeout, logged_in, cur_user, entry_active, locked};
  endfunction

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_SESSION = 3;
  int m_phase, m_idle, m_cur, m_name, m_code;
  int m_digits[$];
  int m_pw[NU];
  int m_fails[NU];
  bit m_li, m_ok, m_fail, m_to;

  task automatic model_reset();
    m_phase = M_IDLE; m_digits.delete(); m_idle = 0; m_cur = 0;
    m_li = 0; m_ok = 0; m_fail = 0; m_to = 0; m_name = 0; m_code = 0;
    for (int i = 0; i < NU; i++) begin
      m_pw[i] = i;
      m_fails[i] = 0;
    end
  endtask

  function automatic int bcd_val(input logic [15:0] b);
    int v;
    v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  task automatic model_step(input bit kv, input int k, input bit pwe, input int pu, input logic [15:0] pp);
    m_ok = 0; m_fail = 0; m_to = 0;
    if (m_phase == M_CHECK) begin
      if (m_name < NU && m_fails[m_name] < MF && m_pw[m_name] == m_code) begin
        m_phase = M_SESSION; m_li = 1; m_cur = m_name; m_fails[m_name] = 0; m_ok = 1;
      end else begin
        m_phase = M_IDLE; m_fail = 1;
        if (m_name < NU && m_fails[m_name] < MF) m_fails[m_name]++;
      end
    end else if (kv && k == 10) begin
      m_phase = M_ENTRY; m_digits.delete(); m_idle = 0; m_li = 0; m_cur = 0;
    end else if (m_phase == M_SESSION) begin
      if (kv && k == 11) begin
        m_phase = M_IDLE; m_li = 0; m_cur = 0;
      end
    end else if (m_phase == M_ENTRY) begin
      if (!kv) begin
        m_idle++;
        if (m_idle == TO) begin
          m_phase = M_IDLE; m_to = 1;
        end
      end else begin
        m_idle = 0;
        if (k == 11) m_phase = M_IDLE;
        else if (k <= 9) begin
          m_digits.push_back(k);
          if (m_digits.size() == UD + PD) begin
            m_name = 0; m_code = 0;
            for (int i = 0; i < UD; i++) m_name = m_name * 10 + m_digits[i];
            for (int i = 0; i < PD; i++) m_code = m_code * 10 + m_digits[UD+i];
            m_phase = M_CHECK;
          end
        end
      end
    end
    if (pwe && pu < NU) begin
      m_pw[pu] = bcd_val(pp);
      m_fails[pu] = 0;
    end
  endtask

  function automatic logic [15:0] model_outs();
    logic [7:0] lk;
    for (int i = 0; i < NU; i++) lk[i] = (m_fails[i] >= MF);
    return pk(m_ok, m_fail, m_to, m_li, m_cur, (m_phase == M_ENTRY) || (m_phase == M_CHECK), lk);
  endfunction

  function automatic int digit_at(input int v, input int pos, input int ndig);
    int p;
    p = 1;
    for (int i = 0; i < ndig - 1 - pos; i++) p = p * 10;
    return (v / p) % 10;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        kv;
    logic [3:0]  k;
    logic        pwe;
    logic [2:0]  pu;
    logic [15:0] pp;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit kv, input int k, input bit pwe, input int pu,
                     input logic [15:0] pp, input logic [15:0] e);
    vec_t v;
    v.kv = kv; v.k = 4'(k); v.pwe = pwe; v.pu = 3'(pu); v.pp = pp; v.exp = e;
    tbl.push_back(v);
  endtask

  // Star + 7 digits from IDLE, then one idle cycle that shows the result pulse.
  task automatic add_login(input int u, input int p, input bit good,
                           input logic [7:0] lkb, input logic [7:0] lka);
    int d[7];
    d = '{(u/100)%10, (u/10)%10, u%10, (p/1000)%10, (p/100)%10, (p/10)%10, p%10};
    add(1, 10, 0, 0, 16'h0, pk(0, 0, 0, 0, 0, 1, lkb));
    foreach (d[i]) add(1, d[i], 0, 0, 16'h0, pk(0, 0, 0, 0, 0, 1, lkb));
    add(0, 0, 0, 0, 16'h0, pk(good, !good, 0, good, good ? u : 0, 0, lka));
  endtask

  // ---------------- directed helpers ----------------
  task automatic apply(input bit kv, input int k, input bit pwe, input int pu, input logic [15:0] pp);
    key_valid = kv; key = 4'(k); prog_we = pwe; prog_user = 3'(pu); prog_pass = pp;
    @(posedge clk); #1;
  endtask
  task automatic press(input int k); apply(1, k, 0, 0, 16'h0); endtask
  task automatic idle1(); apply(0, 0, 0, 0, 16'h0); endtask
  task automatic enter(input int u, input int p);
    press(10);
    press((u/100)%10); press((u/10)%10); press(u%10);
    press((p/1000)%10); press((p/100)%10); press((p/10)%10); press(p%10);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 32'(outs()), 32'h0);
    rst = 1'b1;

    // Table-driven vectors
    add_login(1, 1, 1, 8'h00, 8'h00);
    add(1, 12, 0, 0, 16'h0, pk(0, 0, 0, 1, 1, 0, 8'h00));   // ignored code in session
    add(1, 11, 0, 0, 16'h0, pk(0, 0, 0, 0, 0, 0, 8'h00));   // hash logs out
    add(1, 11, 0, 0, 16'h0, pk(0, 0, 0, 0, 0, 0, 8'h00));   // hash in idle ignored
    add(1, 5, 0, 0, 16'h0, pk(0, 0, 0, 0, 0, 0, 8'h00));    // digit in idle ignored
    add_login(9, 9, 0, 8'h00, 8'h00);                        // out of range user
    add_login(2, 3, 0, 8'h00, 8'h00);
    add_login(2, 3, 0, 8'h00, 8'h00);
    add_login(2, 3, 0, 8'h00, 8'h04);                        // third miss locks
    add_login(2, 2, 0, 8'h04, 8'h04);                        // right code, but locked
    add(0, 0, 1, 2, 16'h4321, pk(0, 0, 0, 0, 0, 0, 8'h00));  // reprogram unlocks
    add_login(2, 4321, 1, 8'h00, 8'h00);
    add(1, 11, 0, 0, 16'h0, pk(0, 0, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].kv, int'(tbl[i].k), tbl[i].pwe, int'(tbl[i].pu), tbl[i].pp);
      $display("vec %0d kv=%0b key=%0d we=%0b outs=0x%04h want=0x%04h",
               i, tbl[i].kv, tbl[i].k, tbl[i].pwe, outs(), tbl[i].exp);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // Idle timeout boundary
    press(10); press(0); press(0);
    for (int i = 0; i < TO - 1; i++) begin
      idle1();
      chk("to_early", 32'({timeout, entry_active}), 32'h1);
    end
    idle1();
    chk("to_pulse", 32'({timeout, entry_active}), 32'h2);
    idle1();
    chk("to_single", 32'(timeout), 32'h0);
    $display("seq timeout done");

    // Star restarts entry mid-username
    press(10); press(0); press(10); press(0); press(0); press(3);
    press(0); press(0); press(0); press(3);
    idle1();
    chk("restart_ok", 32'({login_ok, logged_in, cur_user}), 32'h1B);
    press(11);
    chk("restart_logout", 32'(logged_in), 32'h0);
    $display("seq restart done");

    // Programming during CHECK compares against the old password
    enter(3, 3);
    apply(0, 0, 1, 3, 16'h9999);
    chk("prog_chk_pre", 32'({login_ok, login_fail}), 32'h2);
    press(11);
    enter(3, 3); idle1();
    chk("prog_old_pw", 32'({login_ok, login_fail}), 32'h1);
    enter(3, 9999); idle1();
    chk("prog_new_pw", 32'({login_ok, login_fail, cur_user}), 32'h13);
    press(11);

    // Programming clear beats the third-miss increment
    enter(4, 0); idle1();
    enter(4, 0); idle1();
    chk("two_miss_unlocked", 32'(locked[4]), 32'h0);
    enter(4, 0);
    apply(0, 0, 1, 4, 16'h0004);
    chk("prog_over_inc", 32'({login_fail, locked[4]}), 32'h2);
    enter(4, 0); idle1();
    enter(4, 0); idle1();
    chk("count_restarted", 32'(locked[4]), 32'h0);
    enter(4, 4); idle1();
    chk("user4_ok", 32'({login_ok, cur_user}), 32'hC);
    press(11);

    // Session survives reprogramming of its own user
    enter(1, 1); idle1();
    apply(0, 0, 1, 1, 16'h5555);
    chk("session_keep", 32'({logged_in, cur_user}), 32'h9);
    press(11);
    $display("seq prog done");

    // Reset in the middle of the password
    press(10); press(0); press(0); press(1); press(0);
    chk("in_pass", 32'(entry_active), 32'h1);
    #2 rst = 1'b0;
    #1 chk("rst_async", 32'(outs()), 32'h0);
    @(posedge clk); #1;
    chk("rst_hold", 32'(outs()), 32'h0);
    rst = 1'b1;
    idle1();
    chk("rst_nopulse", 32'(outs()), 32'h0);
    enter(1, 1); idle1();
    chk("rst_relogin", 32'({login_ok, logged_in, cur_user}), 32'h19);
    press(11);
    $display("seq reset done");

    // Random traffic against the reference model
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    begin
      int burst;
      burst = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        bit kv, pwe, do_rst;
        int k, pu, r, n, u;
        logic [15:0] pp;
        if (burst > 0) begin
          burst--; kv = 0;
        end else if ($urandom_range(0, 199) == 0) begin
          burst = TO + 5; kv = 0;
        end else begin
          kv = ($urandom_range(0, 99) < 65);
        end
        k = 0;
        if (kv) begin
          r = int'($urandom_range(0, 99));
          n = m_digits.size();
          if (r < 6) k = 10;
          else if (r < 10) k = 11;
          else if (r < 15) k = int'($urandom_range(12, 15));
          else if (m_phase == M_ENTRY && n < UD - 1)
            k = ($urandom_range(0, 99) < 85) ? 0 : int'($urandom_range(0, 9));
          else begin
            k = int'($urandom_range(0, 9));
            if (m_phase == M_ENTRY && n >= UD && $urandom_range(0, 1) == 1) begin
              u = 0;
              for (int i = 0; i < UD; i++) u = u * 10 + m_digits[i];
              if (u < NU) k = digit_at(m_pw[u], n - UD, PD);
            end
          end
        end
        pwe = ($urandom_range(0, 99) < 2);
        pu = int'($urandom_range(0, NU - 1));
        for (int i = 0; i < 4; i++) pp[4*i +: 4] = 4'($urandom_range(0, 9));
        do_rst = ($urandom_range(0, 999) == 0);
        key_valid = kv; key = 4'(k); prog_we = pwe; prog_user = 3'(pu); prog_pass = pp;
        if (do_rst) rst = 1'b0;
        @(posedge clk); #1;
        if (do_rst) model_reset();
        else model_step(kv, k, pwe, pu, pp);
        if (m_ok || m_fail || m_to || do_rst)
          $display("rand cyc=%0d ok=%0b reject=%0b tmo=%0b rst=%0b user=%0d", cyc, m_ok, m_fail, m_to, do_rst, m_cur);
        chk($sformatf("rand%0d", cyc), 32'(outs()), 32'(model_outs()));
        rst = 1'b1;
      end
    end
    key_valid = 1'b0; prog_we = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
